// File: rtl/prefetch_ctrl64_pkg.sv
// Shared types and constants for the 64-bit instruction prefetch controller.
package prefetch_ctrl64_pkg;

  typedef enum logic [1:0] {
    IDLE           = 2'd0,
    WAIT_GNT       = 2'd1,
    WAIT_GNT_STALE = 2'd2
  } pf_state_e;

  localparam int unsigned FETCH_BEAT_BYTES = 8;

  function automatic logic [31:0] next_beat(input logic [31:0] addr);
    return addr + 32'(FETCH_BEAT_BYTES);
  endfunction

endpackage

// File: rtl/prefetch_ctrl64_outstanding_trk.sv
// In-order slot shift register for granted-but-unanswered fetches: occupancy,
// discard mark, beat address and alignment, with slot 0 always the oldest.
module pf_outstanding_trk
  import prefetch_ctrl64_pkg::*;
#(
  parameter int unsigned NUM_REQS = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                push_i,
  input  logic                push_discard_i,
  input  logic [31:0]         push_addr_i,
  input  logic                push_align_i,
  input  logic                rvalid_i,
  input  logic                flush_i,
  output logic [NUM_REQS-1:0] outstanding_o,
  output logic [NUM_REQS-1:0] discard_o,
  output logic [31:0]         head_addr_o,
  output logic                head_align_o
);

  logic [NUM_REQS-1:0] out_q, out_d;
  logic [NUM_REQS-1:0] dis_q, dis_d;
  logic [31:0]         addr_q [NUM_REQS];
  logic [31:0]         addr_d [NUM_REQS];
  logic                algn_q [NUM_REQS];
  logic                algn_d [NUM_REQS];
  logic                pop;
  logic                placed;

  // A response with nothing outstanding is dropped instead of popping.
  assign pop = rvalid_i & out_q[0];

  always_comb begin
    out_d  = out_q;
    dis_d  = dis_q | ({NUM_REQS{flush_i}} & out_q);
    addr_d = addr_q;
    algn_d = algn_q;
    placed = 1'b0;
    if (pop) begin
      for (int i = 0; i < NUM_REQS - 1; i++) begin
        out_d[i]  = out_d[i+1];
        dis_d[i]  = dis_d[i+1];
        addr_d[i] = addr_d[i+1];
        algn_d[i] = algn_d[i+1];
      end
      out_d[NUM_REQS-1] = 1'b0;
      dis_d[NUM_REQS-1] = 1'b0;
    end
    // New grant lands in the lowest slot left free after any pop.
    if (push_i) begin
      for (int i = 0; i < NUM_REQS; i++) begin
        if (!out_d[i] && !placed) begin
          out_d[i]  = 1'b1;
          dis_d[i]  = push_discard_i;
          addr_d[i] = push_addr_i;
          algn_d[i] = push_align_i;
          placed    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_q <= '0;
      dis_q <= '0;
      for (int i = 0; i < NUM_REQS; i++) begin
        addr_q[i] <= '0;
        algn_q[i] <= 1'b1;
      end
    end else begin
      out_q  <= out_d;
      dis_q  <= dis_d;
      addr_q <= addr_d;
      algn_q <= algn_d;
    end
  end

  assign outstanding_o = out_q;
  assign discard_o     = dis_q;
  assign head_addr_o   = addr_q[0];
  assign head_align_o  = algn_q[0];

  rvalid_needs_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i) rvalid_i |-> out_q[0]
  );

endmodule

// File: rtl/prefetch_ctrl64.sv
// Instruction prefetch sequencer: walks the fetch pointer in 8-byte beats,
// runs the bus request/grant handshake and feeds in-order responses to the FIFO.
module prefetch_ctrl64
  import prefetch_ctrl64_pkg::*;
#(
  parameter int unsigned NUM_REQS       = 2,
  parameter bit          UnalignedFetch = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                req_i,
  input  logic                branch_i,
  input  logic [31:0]         branch_addr_i,
  output logic                instr_req_o,
  input  logic                instr_gnt_i,
  output logic [31:0]         instr_addr_o,
  input  logic                instr_rvalid_i,
  input  logic [63:0]         instr_rdata_i,
  input  logic                instr_err_i,
  output logic                fifo_clear_o,
  input  logic [NUM_REQS-1:0] fifo_busy_i,
  output logic                fifo_valid_o,
  output logic [31:0]         fifo_addr_o,
  output logic [63:0]         fifo_rdata_o,
  output logic                fifo_err_o,
  output logic                fifo_align64_o,
  output logic                busy_o
);

  // Bus handshake: a request transfers on any cycle with instr_req_o & instr_gnt_i;
  // once raised, instr_req_o and instr_addr_o stay fixed until that grant.
  // Responses arrive in grant order, one beat per instr_rvalid_i.

  pf_state_e state_q, state_d;
  logic [31:0] ptr_q, ptr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] base_q, base_d;
  logic        align_q, align_d;

  logic [31:0]         redir_base;
  logic                redir_align;
  logic [NUM_REQS-1:0] outstanding, discard, live_rev;
  logic [31:0]         head_addr;
  logic                head_align;
  logic                fifo_ready, eligible;
  logic                req_c, push, push_discard;
  logic [31:0]         addr_c;

  assign redir_base  = UnalignedFetch ? {branch_addr_i[31:2], 2'b00} : {branch_addr_i[31:3], 3'b000};
  assign redir_align = UnalignedFetch ? ~branch_addr_i[2] : 1'b1;

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      live_rev[i] = outstanding[NUM_REQS-1-i] & ~discard[NUM_REQS-1-i];
    end
  end

  assign fifo_ready = branch_i | ~&(fifo_busy_i | live_rev);
  assign eligible   = req_i & ~outstanding[NUM_REQS-1] & fifo_ready;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    addr_d       = addr_q;
    base_d       = base_q;
    align_d      = branch_i ? redir_align : align_q;
    req_c        = 1'b0;
    addr_c       = addr_q;
    push_discard = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A request issued during the redirect cycle already targets the new base.
        req_c  = eligible;
        addr_c = branch_i ? redir_base : ptr_q;
        if (branch_i) ptr_d = redir_base;
        if (eligible) begin
          addr_d = addr_c;
          if (instr_gnt_i) ptr_d = next_beat(addr_c);
          else             state_d = WAIT_GNT;
        end
      end
      WAIT_GNT: begin
        req_c = 1'b1;
        if (instr_gnt_i) begin
          state_d = IDLE;
          if (branch_i) begin
            push_discard = 1'b1;
            ptr_d        = redir_base;
          end else begin
            ptr_d = next_beat(addr_q);
          end
        end else if (branch_i) begin
          base_d  = redir_base;
          state_d = WAIT_GNT_STALE;
        end
      end
      WAIT_GNT_STALE: begin
        // The pending address is obsolete but must still be completed on the bus.
        req_c = 1'b1;
        if (branch_i) base_d = redir_base;
        if (instr_gnt_i) begin
          push_discard = 1'b1;
          state_d      = IDLE;
          ptr_d        = branch_i ? redir_base : base_q;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst_i) req_c = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      addr_q  <= '0;
      base_q  <= '0;
      align_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      base_q  <= base_d;
      align_q <= align_d;
    end
  end

  assign push = req_c & instr_gnt_i;

  pf_outstanding_trk #(.NUM_REQS(NUM_REQS)) u_trk (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .push_i         (push),
    .push_discard_i (push_discard),
    .push_addr_i    (addr_c),
    .push_align_i   (align_d),
    .rvalid_i       (instr_rvalid_i),
    .flush_i        (branch_i),
    .outstanding_o  (outstanding),
    .discard_o      (discard),
    .head_addr_o    (head_addr),
    .head_align_o   (head_align)
  );

  assign instr_req_o    = req_c;
  assign instr_addr_o   = addr_c;
  assign fifo_clear_o   = branch_i;
  assign fifo_valid_o   = instr_rvalid_i & outstanding[0] & ~discard[0] & ~branch_i & ~rst_i;
  assign fifo_addr_o    = branch_i ? branch_addr_i : head_addr;
  assign fifo_rdata_o   = instr_rdata_i;
  assign fifo_err_o     = instr_err_i;
  assign fifo_align64_o = head_align;
  assign busy_o         = (|outstanding) | req_c;

endmodule

// File: tb/tb_prefetch_ctrl64.sv
// Directed and randomized bench for prefetch_ctrl64 against a transaction-level
// model of the fetch stream (pending request + queue of outstanding beats).
module tb_prefetch_ctrl64;
  import prefetch_ctrl64_pkg::*;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst, req, br, gnt, rv, err;
  logic [31:0]   ba;
  logic [63:0]   rdata;
  logic [N-1:0]  fbusy;

  logic          instr_req_u, fifo_clear_u, fifo_valid_u, fifo_err_u, fifo_align64_u, busy_u;
  logic [31:0]   instr_addr_u, fifo_addr_u;
  logic [63:0]   fifo_rdata_u;
  logic          instr_req_a, fifo_clear_a, fifo_valid_a, fifo_err_a, fifo_align64_a, busy_a;
  logic [31:0]   instr_addr_a, fifo_addr_a;
  logic [63:0]   fifo_rdata_a;

  // ---------------- clock / DUTs ----------------
  always #5 clk = ~clk;

  prefetch_ctrl64 #(.NUM_REQS(N), .UnalignedFetch(1'b1)) u1 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .branch_i(br), .branch_addr_i(ba),
    .instr_req_o(instr_req_u), .instr_gnt_i(gnt), .instr_addr_o(instr_addr_u),
    .instr_rvalid_i(rv), .instr_rdata_i(rdata), .instr_err_i(err),
    .fifo_clear_o(fifo_clear_u), .fifo_busy_i(fbusy), .fifo_valid_o(fifo_valid_u),
    .fifo_addr_o(fifo_addr_u), .fifo_rdata_o(fifo_rdata_u), .fifo_err_o(fifo_err_u),
    .fifo_align64_o(fifo_align64_u), .busy_o(busy_u)
  );

  prefetch_ctrl64 #(.NUM_REQS(N), .UnalignedFetch(1'b0)) u0 (
    .clk_i(clk), .rst_i(rst), .req_i(req), .branch_i(br), .branch_addr_i(ba),
    .instr_req_o(instr_req_a), .instr_gnt_i(gnt), .instr_addr_o(instr_addr_a),
    .instr_rvalid_i(rv), .instr_rdata_i(rdata), .instr_err_i(err),
    .fifo_clear_o(fifo_clear_a), .fifo_busy_i(fbusy), .fifo_valid_o(fifo_valid_a),
    .fifo_addr_o(fifo_addr_a), .fifo_rdata_o(fifo_rdata_a), .fifo_err_o(fifo_err_a),
    .fifo_align64_o(fifo_align64_a), .busy_o(busy_a)
  );

  // ---------------- reference model (UnalignedFetch=1 instance) ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        align;
    logic        dis;
  } ent_t;

  ent_t        mq[$];
  logic [63:0] exp_q[$];
  logic [31:0] m_ptr, m_pend_addr, m_stale_base;
  logic        m_align, m_pend, m_stale;
  logic        e_req, e_valid;
  logic [31:0] e_addr;
  int          checks = 0;
  int          passed = 0;

  function automatic logic [63:0] beat_data(input logic [31:0] a);
    return {~a, a};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h want %0h", tag, obs, exp);
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 64'(obs), 64'(exp));
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk(tag, 64'(obs), 64'(exp));
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    m_ptr = '0; m_align = 1'b1; m_pend = 1'b0; m_stale = 1'b0;
    m_pend_addr = '0; m_stale_base = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic b, input logic [31:0] a, input logic g,
                       input logic v, input logic e, input logic [N-1:0] bz);
    @(negedge clk);
    rst = 1'b0; req = r; br = b; ba = a; gnt = g; err = e; fbusy = bz;
    rv = v && (mq.size() > 0);
    rdata = (mq.size() > 0) ? beat_data(mq[0].addr) : 64'h0;
    #1;
  endtask

  task automatic eval_and_check();
    logic [31:0] base;
    logic        blocked, ready;
    int          idx;
    base = {ba[31:2], 2'b00};
    if (m_pend) begin
      e_req  = 1'b1;
      e_addr = m_pend_addr;
    end else begin
      blocked = 1'b1;
      for (int j = 0; j < N; j++) begin
        idx = N - 1 - j;
        if (!(fbusy[j] || (idx < mq.size() && !mq[idx].dis))) blocked = 1'b0;
      end
      ready  = br || !blocked;
      e_req  = req && (mq.size() < N) && ready;
      e_addr = br ? base : m_ptr;
    end
    e_valid = 1'b0;
    if (rv && mq.size() > 0) e_valid = !mq[0].dis && !br;
    chk1("instr_req", instr_req_u, e_req);
    chk32("instr_addr", instr_addr_u, e_addr);
    chk1("fifo_valid", fifo_valid_u, e_valid);
    chk1("fifo_clear", fifo_clear_u, br);
    chk1("busy", busy_u, (mq.size() > 0) || e_req);
    if (br) chk32("fifo_addr_redirect", fifo_addr_u, ba);
    if (e_valid) begin
      chk32("fifo_addr_beat", fifo_addr_u, mq[0].addr);
      chk1("fifo_align64", fifo_align64_u, mq[0].align);
      chk1("fifo_err", fifo_err_u, err);
      exp_q.push_back(beat_data(mq[0].addr));
    end
    if (fifo_valid_u && exp_q.size() > 0) chk("sb_rdata", fifo_rdata_u, exp_q.pop_front());
  endtask

  task automatic tick();
    logic [31:0] base;
    logic        nal, stale_hit;
    ent_t        ne;
    @(posedge clk);
    base = {ba[31:2], 2'b00};
    nal  = ~ba[2];
    if (br) foreach (mq[i]) mq[i].dis = 1'b1;
    if (rv && mq.size() > 0) void'(mq.pop_front());
    if (e_req && gnt) begin
      stale_hit = m_pend && (br || m_stale);
      ne.addr   = e_addr;
      ne.align  = br ? nal : m_align;
      ne.dis    = stale_hit;
      mq.push_back(ne);
      m_ptr   = stale_hit ? (br ? base : m_stale_base) : e_addr + 32'd8;
      m_pend  = 1'b0;
      m_stale = 1'b0;
    end else if (e_req) begin
      if (!m_pend) begin
        m_pend      = 1'b1;
        m_pend_addr = e_addr;
      end else if (br) begin
        m_stale      = 1'b1;
        m_stale_base = base;
      end
    end else if (br) begin
      m_ptr = base;
    end
    if (br) m_align = nal;
  endtask

  task automatic step(input logic r, input logic b, input logic [31:0] a, input logic g,
                      input logic v, input logic e, input logic [N-1:0] bz);
    drive(r, b, a, g, v, e, bz);
    eval_and_check();
    tick();
  endtask

  task automatic do_reset(input logic r_req);
    @(negedge clk);
    rst = 1'b1; req = r_req; br = 1'b0; ba = '0; gnt = 1'b1; rv = 1'b0; err = 1'b0;
    fbusy = '0; rdata = '0;
    #1;
    chk1("rst_req_during", instr_req_u, 1'b0);
    chk1("rst_valid_during", fifo_valid_u, 1'b0);
    @(posedge clk);
    model_reset();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0);
    chk1("post_rst_req", instr_req_u, 1'b0);
    chk32("post_rst_addr", instr_addr_u, 32'h0);
    chk1("post_rst_valid", fifo_valid_u, 1'b0);
    chk1("post_rst_clear", fifo_clear_u, 1'b0);
    chk1("post_rst_busy", busy_u, 1'b0);
    eval_and_check();
    tick();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req = 1'b0; br = 1'b0; ba = '0; gnt = 1'b0; rv = 1'b0; err = 1'b0;
    fbusy = '0; rdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    do_reset(1'b0);

    // Back-to-back burst from address 0.
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, '0); eval_and_check();
    chk32("burst_addr0", instr_addr_u, 32'h0); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, '0); eval_and_check();
    chk32("burst_addr8", instr_addr_u, 32'h8);
    chk1("burst_valid0", fifo_valid_u, 1'b1);
    chk1("burst_align0", fifo_align64_u, 1'b1); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, '0); eval_and_check();
    chk32("burst_addr10", instr_addr_u, 32'h10);
    chk1("burst_valid8", fifo_valid_u, 1'b1); tick();
    do_reset(1'b1);

    // Redirect to a 4-byte offset target.
    drive(1'b1, 1'b1, 32'h1006, 1'b1, 1'b0, 1'b0, '0); eval_and_check();
    chk1("redir_clear", fifo_clear_u, 1'b1);
    chk32("redir_fifo_addr", fifo_addr_u, 32'h1006);
    chk32("redir_fetch_u", instr_addr_u, 32'h1004);
    chk32("redir_fetch_a", instr_addr_a, 32'h1000); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, '0); eval_and_check();
    chk32("redir_next_u", instr_addr_u, 32'h100C);
    chk32("redir_next_a", instr_addr_a, 32'h1008);
    chk1("redir_valid", fifo_valid_u, 1'b1);
    chk1("redir_align_u", fifo_align64_u, 1'b0);
    chk32("redir_beat_u", fifo_addr_u, 32'h1004);
    chk1("redir_align_a", fifo_align64_a, 1'b1);
    chk32("redir_beat_a", fifo_addr_a, 32'h1000); tick();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, '0);

    // Two outstanding, then redirect: both old beats dropped.
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, '0);
    step(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b1, 32'h2000, 1'b1, 1'b1, 1'b0, '0); eval_and_check();
    chk1("flush_full_noreq", instr_req_u, 1'b0);
    chk1("flush_drop0", fifo_valid_u, 1'b0); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, '0); eval_and_check();
    chk1("flush_drop1", fifo_valid_u, 1'b0);
    chk32("flush_new_addr", instr_addr_u, 32'h2000); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, '0); eval_and_check();
    chk1("flush_new_valid", fifo_valid_u, 1'b1);
    chk32("flush_new_beat", fifo_addr_u, 32'h2000); tick();

    // Grant stall with a redirect while waiting.
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0); eval_and_check();
    chk32("stall_addr_c1", instr_addr_u, 32'h2008); tick();
    drive(1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 1'b0, '0); eval_and_check();
    chk32("stall_addr_c2", instr_addr_u, 32'h2008); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, '0); eval_and_check();
    chk32("stall_addr_c3", instr_addr_u, 32'h2008);
    chk1("stall_req_held", instr_req_u, 1'b1);
    chk("stall_state", 64'(u1.state_q), 64'(WAIT_GNT_STALE)); tick();
    step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, '0);
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, '0); eval_and_check();
    chk32("stale_next_addr", instr_addr_u, 32'h3000);
    chk1("stale_drop", fifo_valid_u, 1'b0); tick();
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, '0); eval_and_check();
    chk1("stale_new_valid", fifo_valid_u, 1'b1);
    chk32("stale_new_beat", fifo_addr_u, 32'h3000); tick();

    // FIFO back-pressure.
    repeat (2) begin
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b11); eval_and_check();
      chk1("busy_throttle", instr_req_u, 1'b0); tick();
    end
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 2'b00); eval_and_check();
    chk1("busy_release", instr_req_u, 1'b1);
    chk32("busy_release_addr", instr_addr_u, 32'h3008); tick();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, '0);

    // Pointer wrap and error forwarding.
    drive(1'b1, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b0, 1'b0, '0); eval_and_check();
    chk32("wrap_top", instr_addr_u, 32'hFFFF_FFF8); tick();
    drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, '0); eval_and_check();
    chk32("wrap_zero", instr_addr_u, 32'h0);
    chk1("err_fwd", fifo_err_u, 1'b1);
    chk1("err_valid", fifo_valid_u, 1'b1); tick();
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, '0);

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
      end else begin
        step($urandom_range(0, 3) != 0,
             $urandom_range(0, 15) == 0,
             $urandom & 32'hFFFF_FFFE,
             $urandom_range(0, 2) != 0,
             $urandom_range(0, 1) == 1,
             $urandom_range(0, 7) == 0,
             ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 3)) : '0);
      end
    end

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
